// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus the (address, value) output stream of the dump reader.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data,
        output out_last
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks registers 0..NUM_REGS-1 through one read port and streams (addr, value) pairs,
// one item per two cycles at full rate; abort returns to idle without a done pulse.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    regfile_dump_reader_if.master  rf,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            rf.rd_addr   <= '0;
            rf.out_valid <= 1'b0;
            rf.out_addr  <= '0;
            rf.out_data  <= '0;
            rf.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= READ;
                        idx        <= '0;
                        rf.rd_addr <= '0;
                    end
                end
                READ: begin
                    if (abort) begin
                        state        <= IDLE;
                        rf.out_valid <= 1'b0;
                        idx          <= '0;
                        rf.rd_addr   <= '0;
                    end else begin
                        // rd_data is combinational for rd_addr, so the snapshot is taken here
                        rf.out_data  <= rf.rd_data;
                        rf.out_addr  <= idx;
                        rf.out_last  <= (idx == LAST_IDX);
                        rf.out_valid <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state        <= IDLE;
                        rf.out_valid <= 1'b0;
                        idx          <= '0;
                        rf.rd_addr   <= '0;
                    end else if (rf.out_valid && rf.out_ready) begin
                        rf.out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            rf.rd_addr <= idx + 1'b1;
                            state      <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == READ) || (state == WAIT);
    assign done = (state == DONE);
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed scenarios plus a randomized phase, checked cycle by cycle against an item-level model.
module tb_regfile_dump_reader;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ready = 1'b1;
    logic busy, done;
    logic [DW-1:0] regs [N];

    regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign bus.rd_data   = regs[bus.rd_addr[1:0]];
    assign bus.out_ready = ready;

    regfile_dump_reader #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .rf    (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int items = 0;
    int dones = 0;

    // Model: a dump is a list of items; each item is fetched one edge after it is
    // requested, presented until accepted, and the list ends with a one-cycle done.
    bit          m_active, m_fetch, m_done, m_valid, m_last;
    int          m_k;
    logic [AW-1:0] m_addr, m_rdaddr;
    logic [DW-1:0] m_data;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_fetch = 0; m_done = 0; m_valid = 0; m_last = 0;
        m_k = 0; m_addr = '0; m_rdaddr = '0; m_data = '0;
    endtask

    task automatic check_all();
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("busy",      64'(busy),          64'(m_active));
        chk("done",      64'(done),          64'(m_done));
        chk("rd_addr",   64'(bus.rd_addr),   64'(m_rdaddr));
        chk("out_addr",  64'(bus.out_addr),  64'(m_addr));
        chk("out_data",  bus.out_data,       m_data);
        chk("out_last",  64'(bus.out_last),  64'(m_last));
    endtask

    task automatic step();
        bit was_done;
        was_done = m_done;
        m_done   = 0;
        if (bus.out_valid && ready) items++;
        if (m_active) begin
            if (abort) begin
                m_active = 0; m_fetch = 0; m_valid = 0; m_k = 0; m_rdaddr = '0;
            end else if (m_fetch) begin
                m_data  = regs[m_k];
                m_addr  = AW'(m_k);
                m_last  = (m_k == N - 1);
                m_valid = 1;
                m_fetch = 0;
            end else if (m_valid && ready) begin
                m_valid = 0;
                if (m_k == N - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_k++;
                    m_rdaddr = AW'(m_k);
                    m_fetch  = 1;
                end
            end
        end else if (!was_done && start) begin
            m_active = 1; m_fetch = 1; m_k = 0; m_rdaddr = '0;
        end
        @(posedge clk);
        #1;
        check_all();
        if (done) dones++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic until_item(int k);
        for (int i = 0; i < 40; i++) begin
            if (m_valid && m_k == k) return;
            step();
        end
        n_vec++; n_err++;
        $error("FAIL until_item: got no item %0d want item %0d", k, k);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_regs();
        regs[0] = 64'h11; regs[1] = 64'h22; regs[2] = 64'h33; regs[3] = 64'h44;
    endtask

    initial begin
        load_regs();
        model_reset();
        #2 reset = 1'b0;
        #2;
        check_all();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run(2);

        // Full dump at full rate
        items = 0; dones = 0;
        pulse_start();
        run(10);
        chk("full_items", 64'(items), 64'(N));
        chk("full_dones", 64'(dones), 64'd1);

        // Backpressure on item 1 while its register changes
        items = 0; dones = 0;
        pulse_start();
        until_item(1);
        ready = 1'b0;
        regs[1] = 64'h99;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", bus.out_data, 64'h22);
        end
        ready = 1'b1;
        run(12);
        chk("bp_items", 64'(items), 64'(N));
        chk("bp_dones", 64'(dones), 64'd1);
        load_regs();

        // Abort while item 2 waits
        dones = 0;
        pulse_start();
        until_item(2);
        ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        ready = 1'b1;
        run(5);
        chk("abort_dones", 64'(dones), 64'd0);
        pulse_start();
        step();
        chk("restart_first", 64'(bus.out_addr), 64'd0);
        run(10);

        // Start pulses during a dump and during the done cycle are ignored
        items = 0; dones = 0;
        pulse_start();
        until_item(1);
        ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 40 && !m_done; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run(10);
        chk("ign_items", 64'(items), 64'(N));
        chk("ign_dones", 64'(dones), 64'd1);

        // Asynchronous reset in the middle of a wait
        pulse_start();
        until_item(1);
        ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;
        ready = 1'b1;
        dones = 0;
        run(6);
        chk("rst_dones", 64'(dones), 64'd0);

        // Abort together with the final handshake
        dones = 0;
        pulse_start();
        until_item(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        run(4);
        chk("abort_last_dones", 64'(dones), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, N - 1)] = {$urandom, $urandom};
            step();
        end
        start = 1'b0;
        abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side companion to the enable-gated register storage in the register file.
- On a start pulse, walks every register in address order through one register-file read port.
- Presents each (address, value) pair on a valid/ready output stream and holds it stable until accepted.
- Used for debug readback and context snapshot; it never writes the register file.

Parameters:
NUM_REGS, 32, number of registers walked (addresses 0..NUM_REGS-1); must be ≥2
DATA_W, 64, register width in bits
ADDR_W, 5, address width; must satisfy 2**ADDR_W ≥ NUM_REGS

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately)
start  input  1  request a full dump; sampled only in IDLE
abort  input  1  cancel a dump in progress
rd_addr  output  ADDR_W  address driven to register-file read port (registered)
rd_data  input  DATA_W  combinational read data for rd_addr, valid same cycle
out_valid  output  1  out_addr/out_data hold a valid item
out_ready  input  1  consumer accepts item when out_valid && out_ready at rising edge
out_addr  output  ADDR_W  address of presented item
out_data  output  DATA_W  captured register value
out_last  output  1  presented item is address NUM_REGS-1
busy  output  1  high in READ or WAIT
done  output  1  one-cycle pulse after final item accepted

Behaviour:
- Reset (reset=0, async): state=IDLE; idx=0; rd_addr=0; out_valid=0; out_addr=0; out_data=0; out_last=0; done=0.
- All outputs are registered. busy and done are decoded from the registered state.
- State IDLE:
  - start=1 → READ; idx=0; rd_addr=0.
  - start=0 → remain IDLE.
  - abort is ignored in IDLE.
- State READ (one cycle):
  - At the edge: out_data<=rd_data; out_addr<=idx; out_last<=(idx==NUM_REGS-1); out_valid<=1; → WAIT.
- State WAIT:
  - out_data, out_addr and out_last are held stable while out_valid && !out_ready. They are never updated in WAIT.
  - On handshake with idx<NUM_REGS-1: out_valid<=0; idx<=idx+1; rd_addr<=idx+1; → READ.
  - On handshake with idx==NUM_REGS-1: out_valid<=0; → DONE.
- State DONE (one cycle): done=1 → IDLE. start is ignored in DONE.
- Throughput: one item per 2 cycles when out_ready is held high.
- Latency:
  - start edge to first out_valid = 2 edges.
  - Last handshake to done = 1 edge.
  - Full dump with out_ready=1 = 2*NUM_REGS+1 cycles from start to done.
- start while busy: ignored; the dump in progress continues unchanged.
- abort=1 in READ or WAIT: → IDLE at next edge; out_valid<=0; idx<=0; rd_addr<=0; done stays 0.
- abort coincident with handshake in WAIT: the consumer's transfer is considered complete; abort still wins → IDLE, no done pulse.
- abort coincident with start in IDLE: start wins (abort is ignored in IDLE).
- abort=1 in DONE: ignored; the done pulse still occurs.
- No wrap-around: idx never exceeds NUM_REGS-1; addresses ≥NUM_REGS are never driven on rd_addr.
- rd_data changing while in WAIT has no effect on out_data (the snapshot was taken in READ).
- Asynchronous reset during any state behaves identically to power-on reset. No partial item or done pulse may follow deassertion.

Test Plan:
- Bench params NUM_REGS=4, DATA_W=64. Regfile preloaded with reg0..reg3=0x11,0x22,0x33,0x44; out_ready=1; pulse start → items (0,0x11),(1,0x22),(2,0x33),(3,0x44,last=1) on cycles 2,4,6,8 after start; done=1 on cycle 9 only; busy high on cycles 1..8.
- Backpressure: out_ready=0 for 5 cycles on item 1 while regfile reg1 changes 0x22→0x99 → out_data holds 0x22 for all 5 cycles; stream resumes with item 2 after ready asserted.
- Abort mid-dump: abort on WAIT of item 2 → out_valid=0 and busy=0 next cycle, done never pulses; a new start then produces item 0 first.
- Ignored start: start pulsed during item 1 WAIT and again during the DONE cycle → exactly 4 items and one done pulse, no second dump.
- Reset mid-operation: drive reset=0 between edges during WAIT → out_valid, busy and rd_addr go to 0 immediately without a clock; after release there are no outputs until the next start.
- Abort coincident with final handshake (item 3, out_ready=1, abort=1) → IDLE next cycle, done stays 0.
